// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data memory load/store unit.
package dmem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Byte enables for a store; size 3 behaves like a word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addrLo);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << addrLo;
      SZ_HALF: mask = addrLo[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half out of a memory word, right-justifies it and extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        size,
  input  logic [1:0]        addrLo,
  input  logic              isUnsigned,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = word[{addrLo, 3'b000} +: 8];
    halfSel = addrLo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = isUnsigned ? {24'b0, byteSel} : {{24{byteSel[7]}}, byteSel};
      SZ_HALF: data = isUnsigned ? {16'b0, halfSel} : {{16{halfSel[15]}}, halfSel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_banked_lsu.sv
// Data memory with byte/half/word access and a configurable-latency request/response handshake.
// Optional build macro DMEM_MISALIGN_CHK_EN turns misaligned accesses into flagged no-ops.
module dmem_banked_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 8192,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int LA_W  = IDX_W + 2;
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  state_t            state;
  logic [CNT_W-1:0]  waitCnt;
  logic              latWe, latUnsigned;
  logic [1:0]        latSize;
  logic [LA_W-1:0]   latAddr;
  logic [DATA_W-1:0] latWdata;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic              accept, enterResp, commitStore;
  logic              opWe, opUnsigned, opMisaligned;
  logic [1:0]        opSize;
  logic [LA_W-1:0]   opAddr;
  logic [DATA_W-1:0] opWdata, storeData, opWord, alignedData;
  logic [IDX_W-1:0]  opIdx;
  logic [3:0]        opMask;
  logic              unusedHiAddr;

  assign unusedHiAddr = ^req_addr[ADDR_W-1:LA_W];

  assign accept    = (state == IDLE) && req_valid;
  assign enterResp = (accept && (LATENCY == 1)) || ((state == WAIT) && (waitCnt == CNT_W'(1)));

  // With LATENCY==1 the access happens on the accepting edge, so use the live request.
  assign opWe       = (state == IDLE) ? req_we             : latWe;
  assign opSize     = (state == IDLE) ? req_size           : latSize;
  assign opUnsigned = (state == IDLE) ? req_unsigned       : latUnsigned;
  assign opAddr     = (state == IDLE) ? req_addr[LA_W-1:0] : latAddr;
  assign opWdata    = (state == IDLE) ? req_wdata          : latWdata;

  assign opIdx  = opAddr[2 +: IDX_W];
  assign opMask = lane_mask(opSize, opAddr[1:0]);
  assign opWord = mem[opIdx];

`ifdef DMEM_MISALIGN_CHK_EN
  assign opMisaligned = ((opSize == SZ_HALF) && opAddr[0]) || (opSize[1] && (opAddr[1:0] != 2'b00));
`else
  assign opMisaligned = 1'b0;
`endif

  assign commitStore = enterResp && opWe && !opMisaligned && !rst;

  always_comb begin
    case (opSize)
      SZ_BYTE: storeData = {4{opWdata[7:0]}};
      SZ_HALF: storeData = {2{opWdata[15:0]}};
      default: storeData = opWdata;
    endcase
  end

  dmem_load_align u_align (
    .word       (opWord),
    .size       (opSize),
    .addrLo     (opAddr[1:0]),
    .isUnsigned (opUnsigned),
    .data       (alignedData)
  );

  always_ff @(posedge clk) begin
    if (commitStore) begin
      for (int i = 0; i < 4; i++) begin
        if (opMask[i]) mem[opIdx][i*8 +: 8] <= storeData[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            latWe       <= req_we;
            latSize     <= req_size;
            latUnsigned <= req_unsigned;
            latAddr     <= req_addr[LA_W-1:0];
            latWdata    <= req_wdata;
            req_ready   <= 1'b0;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state   <= WAIT;
              waitCnt <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (waitCnt == CNT_W'(1)) begin
            state   <= RESP;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
      if (enterResp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= opMisaligned;
        rsp_rdata <= (opWe || opMisaligned) ? '0 : alignedData;
      end
    end
  end

endmodule
